weight_loader: RTL

Stream-to-RAM writer for the convolution weight store. It accepts a serial valid/ready stream of 16-bit weights for one 3-channel 5x5 kernel (75 words) and assembles them into row buffers. It drives the write side of the weight RAM block (`addr_write`, `write_enable`, `data_in_<col>_<ch>`) with one full-row write per kernel row. It sits between the host/DMA weight feed and the weight RAM block; the convolution datapath uses the read side.

---
 rtl/weight_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/weight_loader.sv
// weight_loader
// Streams one 3-channel 5x5 convolution kernel (75 x DATA_W words) in from a
// valid/ready source and writes it into the weight RAM one kernel row at a time.
// Word order on the stream is channel fastest, then column, then row.
//
// Ports
//   clk, rst_n          : clock (rising edge) and asynchronous active-low reset
//   start               : begins a kernel load, only honoured while idle
//   s_valid/s_data      : incoming weight stream
//   s_ready             : loader takes a word on this cycle when s_valid is high
//   addr_write          : RAM row being written (0 while idle)
//   write_enable        : per-column lane strobe, all lanes fire together on a row write
//   data_in_<c>_<k>     : row buffer, column c, channel k, wired straight to the RAM
//   busy                : a load is in progress
//   done                : single-cycle pulse after the last row write
module weight_loader #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [2:0]        addr_write,
    output logic [4:0]        write_enable,
    output logic [DATA_W-1:0] data_in_0_0,
    output logic [DATA_W-1:0] data_in_0_1,
    output logic [DATA_W-1:0] data_in_0_2,
    output logic [DATA_W-1:0] data_in_1_0,
    output logic [DATA_W-1:0] data_in_1_1,
    output logic [DATA_W-1:0] data_in_1_2,
    output logic [DATA_W-1:0] data_in_2_0,
    output logic [DATA_W-1:0] data_in_2_1,
    output logic [DATA_W-1:0] data_in_2_2,
    output logic [DATA_W-1:0] data_in_3_0,
    output logic [DATA_W-1:0] data_in_3_1,
    output logic [DATA_W-1:0] data_in_3_2,
    output logic [DATA_W-1:0] data_in_4_0,
    output logic [DATA_W-1:0] data_in_4_1,
    output logic [DATA_W-1:0] data_in_4_2,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    state_t state;
    state_t state_next;

    logic [1:0] ch;
    logic [2:0] col;
    logic [2:0] row;

    logic [DATA_W-1:0] lane_q [5][3];

    logic last_word;

    // The final word of a row is the one landing in column 4, channel 2.
    assign last_word = (col == 3'd4) && (ch == 2'd2);

    // State register; reset drops straight back to idle, which also kills any
    // write strobe in flight since all outputs decode from this register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: WRITE and DONE each last exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  if (s_valid && last_word) state_next = S_WRITE;
            S_WRITE: state_next = (row == LAST_ROW) ? S_DONE : S_LOAD;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode from the registered state only, so s_ready never depends
    // combinationally on s_valid.
    always_comb begin
        s_ready      = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        write_enable = 5'b00000;
        addr_write   = row;
        case (state)
            S_IDLE: begin
                busy       = 1'b0;
                addr_write = 3'd0;
            end
            S_LOAD:  s_ready = 1'b1;
            S_WRITE: write_enable = 5'b11111;
            S_DONE:  done = 1'b1;
            default: begin
                busy       = 1'b0;
                addr_write = 3'd0;
            end
        endcase
    end

    // Counters and row buffer. The buffer is only touched on accepted words
    // and on start, so it holds steady through WRITE and keeps the last row
    // visible after the load finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch  <= 2'd0;
            col <= 3'd0;
            row <= 3'd0;
            for (int c = 0; c < 5; c++) begin
                for (int k = 0; k < 3; k++) begin
                    lane_q[c][k] <= '0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ch  <= 2'd0;
                        col <= 3'd0;
                        row <= 3'd0;
                        for (int c = 0; c < 5; c++) begin
                            for (int k = 0; k < 3; k++) begin
                                lane_q[c][k] <= '0;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (s_valid) begin
                        lane_q[col][ch] <= s_data;
                        if (ch == 2'd2) begin
                            ch  <= 2'd0;
                            col <= (col == 3'd4) ? 3'd0 : col + 3'd1;
                        end else begin
                            ch <= ch + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    // Row stays on the last index through DONE so addr_write
                    // still reports it.
                    if (row != LAST_ROW) begin
                        row <= row + 3'd1;
                        col <= 3'd0;
                        ch  <= 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_in_0_0 = lane_q[0][0];
    assign data_in_0_1 = lane_q[0][1];
    assign data_in_0_2 = lane_q[0][2];
    assign data_in_1_0 = lane_q[1][0];
    assign data_in_1_1 = lane_q[1][1];
    assign data_in_1_2 = lane_q[1][2];
    assign data_in_2_0 = lane_q[2][0];
    assign data_in_2_1 = lane_q[2][1];
    assign data_in_2_2 = lane_q[2][2];
    assign data_in_3_0 = lane_q[3][0];
    assign data_in_3_1 = lane_q[3][1];
    assign data_in_3_2 = lane_q[3][2];
    assign data_in_4_0 = lane_q[4][0];
    assign data_in_4_1 = lane_q[4][1];
    assign data_in_4_2 = lane_q[4][2];

endmodule
